traffic_gen: RTL and testbench
==============================

TRAFFIC_GEN -- requirements
Module: traffic_gen

Interface
REQ-001 SHALL have parameter NUM_OPS, default 8: writes per run, then the same number of reads; range 1..65535.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_1000: start of the region for PID 0.
REQ-003 SHALL have parameter STRIDE, default 16: byte step between ops, one 128-bit line.
REQ-004 SHALL have parameter TIMEOUT, default 1024: watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-007 SHALL have port PID, input, 2 bits: core index, static during a run.
REQ-008 SHALL have port start, input, 1 bit: single-cycle run request.
REQ-009 SHALL have L1 CPU-side outputs Valid (1), MemWrite (1), DataAdr (32) and WriteData (32).
REQ-010 SHALL have L1 CPU-side inputs ReadData (32), Ready (1) and CacheHit (1).
REQ-011 SHALL have outputs done (1) and error (1), plus hit_count, miss_count and mismatch_count (16 bits each).

Function
REQ-012 SHALL implement FSM states IDLE, REQ, GAP and DONE, with a phase bit (0 = write, 1 = read) and a 16-bit op index idx.
REQ-013 IDLE: on start=1, SHALL clear idx, phase and all counters, then go to REQ next cycle.
REQ-014 SHALL compute op address as BASE_ADDR + (PID*NUM_OPS + idx)*STRIDE, in 32-bit arithmetic that wraps modulo 2^32.
REQ-015 SHALL compute write pattern as {6'b0, PID, 8'hC0, idx}; read expected value is the same pattern.
REQ-016 REQ: SHALL drive Valid=1 and MemWrite=~phase; DataAdr and WriteData SHALL be held stable until Ready=1 is sampled.
REQ-017 On the cycle Ready=1 is sampled in REQ, SHALL complete the op.
REQ-018 Op completion SHALL increment hit_count if CacheHit=1, otherwise miss_count.
REQ-019 On a read op completion, if ReadData differs from the expected value, SHALL increment mismatch_count and set error.
REQ-020 On op completion SHALL go to GAP; Valid=0 for exactly one cycle between ops.
REQ-021 GAP: if idx=NUM_OPS-1 and phase=0, SHALL set phase=1 and idx=0, then go to REQ.
REQ-022 GAP: if idx=NUM_OPS-1 and phase=1, SHALL go to DONE.
REQ-023 GAP: otherwise SHALL increment idx, then go to REQ.
REQ-024 DONE: SHALL hold done=1 and Valid=0; start=1 SHALL restart as in REQ-013 and clear done and error.
REQ-025 start SHALL be ignored in REQ and GAP.
REQ-026 hit_count, miss_count and mismatch_count SHALL saturate at 16'hFFFF.
REQ-027 Ready=1 outside REQ SHALL be ignored.

Reset
REQ-028 reset=1 SHALL immediately force the following, independent of clk, including mid-transaction: state IDLE; Valid=0, MemWrite=0, DataAdr=0, WriteData=0; done=0, error=0; all counters 0; idx=0, phase=0.
REQ-029 After reset deasserts, the block SHALL stay in IDLE until start=1.

Configuration
REQ-030 Macro TRAFFIC_GEN_WATCHDOG_EN defined: SHALL provide a 16-bit cycle counter cleared on entry to REQ and incremented each REQ cycle without Ready.
REQ-031 With the macro defined, on reaching TIMEOUT the block SHALL set error, drop Valid and go to DONE.
REQ-032 Macro undefined: no watchdog logic; REQ SHALL wait for Ready indefinitely.

Structure
REQ-033 The state enum (IDLE/REQ/GAP/DONE) and the data-pattern tag constant 8'hC0 SHALL live in shared package coherence_pkg.
REQ-034 One sub-module, sat_counter (16-bit saturating counter with clear and increment), SHALL be instantiated three times.

Verification
REQ-035 PID=0, NUM_OPS=2, L1 model with Ready after 3 cycles -> addresses 0x1000, 0x1010 written with 0x00C00000 and 0x00C00001, then read; done=1, error=0.
REQ-036 PID=3, NUM_OPS=8 -> first DataAdr=0x1180, first WriteData=0x03C00000.
REQ-037 Read of idx 1 returns 0xDEADBEEF -> mismatch_count=1, error=1, run still reaches done=1.
REQ-038 CacheHit=1 on reads only, NUM_OPS=4 -> hit_count=4, miss_count=4.
REQ-039 reset pulsed while Valid=1 in REQ -> Valid=0 same cycle, all outputs 0; new start re-runs from idx 0.
REQ-040 Watchdog enabled, TIMEOUT=16, Ready held 0 -> error=1 and done=1 after 16 REQ cycles; disabled -> Valid stays 1.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared types and constants for the L1 traffic generator: FSM states,
// data-pattern tag and the CPU-side request payload.
package coherence_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic [7:0] PATTERN_TAG = 8'hC0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic              mem_write;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdata;
  } l1_req_t;

  // Data word written at op idx by core pid; reads expect the same word back.
  function automatic logic [DATA_W-1:0] op_pattern(input logic [1:0]       pid,
                                                   input logic [CNT_W-1:0] idx);
    return {6'b0, pid, PATTERN_TAG, idx};
  endfunction

endpackage

// File: rtl/traffic_gen_sat_counter.sv
// sat_counter: W-bit event counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_gen.sv
// traffic_gen: per-core write-then-read-back traffic source for an L1 CPU port.
// Optional watchdog on stalled requests: define TRAFFIC_GEN_WATCHDOG_EN.
module traffic_gen
  import coherence_pkg::*;
#(
  parameter int unsigned NUM_OPS   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int unsigned STRIDE    = 16,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PID,
  input  logic        start,
  output logic        Valid,
  output logic        MemWrite,
  output logic [31:0] DataAdr,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData,
  input  logic        Ready,
  input  logic        CacheHit,
  output logic        done,
  output logic        error,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
  output logic [15:0] mismatch_count
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

  state_e           state_q, state_d;
  logic             phase_q, phase_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  l1_req_t          req_q, req_d;

  logic start_c, complete_c, last_c, mismatch_c, timeout_c;

  function automatic logic [ADDR_W-1:0] op_addr(input logic [1:0]       pid,
                                                input logic [CNT_W-1:0] idx);
    return BASE_ADDR + (ADDR_W'(pid) * ADDR_W'(NUM_OPS) + ADDR_W'(idx)) * ADDR_W'(STRIDE);
  endfunction

  assign start_c    = start && ((state_q == IDLE) || (state_q == DONE));
  assign complete_c = (state_q == REQ) && Ready;
  assign last_c     = (idx_q == LAST_IDX);
  assign mismatch_c = complete_c && phase_q && (ReadData != op_pattern(PID, idx_q));

`ifdef TRAFFIC_GEN_WATCHDOG_EN
  // Counts consecutive REQ cycles without Ready; zero whenever outside REQ.
  logic [CNT_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (state_q != REQ) begin
      wd_d = '0;
    end else if (!Ready) begin
      wd_d = wd_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout_c = (state_q == REQ) && !Ready && (wd_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ: begin
        if (Ready) begin
          state_d = GAP;
        end else if (timeout_c) begin
          state_d = DONE;
        end
      end
      GAP:     state_d = (last_c && phase_q) ? DONE : REQ;
      DONE:    if (start) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs follow the next state so they line up with it.
  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    error_d = error_q;
    req_d   = req_q;
    if (start_c) begin
      phase_d = 1'b0;
      idx_d   = '0;
      error_d = 1'b0;
    end
    if ((state_q == GAP) && !(last_c && phase_q)) begin
      if (last_c) begin
        phase_d = 1'b1;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end
    if (mismatch_c || timeout_c) begin
      error_d = 1'b1;
    end
    valid_d = (state_d == REQ);
    done_d  = (state_d == DONE);
    if (state_d == REQ) begin
      req_d.mem_write = !phase_d;
      req_d.adr       = op_addr(PID, idx_d);
      req_d.wdata     = op_pattern(PID, idx_d);
    end else begin
      req_d.mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      req_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
      req_q   <= req_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_c),
    .inc   (complete_c && CacheHit),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_c),
    .inc   (complete_c && !CacheHit),
    .count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_mismatch_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_c),
    .inc   (mismatch_c),
    .count (mismatch_count)
  );

  assign Valid     = valid_q;
  assign MemWrite  = req_q.mem_write;
  assign DataAdr   = req_q.adr;
  assign WriteData = req_q.wdata;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_traffic_gen.sv
// Scoreboard bench for traffic_gen (NUM_OPS=4, TIMEOUT=16) with a small L1 responder.
module tb_traffic_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  pid;
  logic        start;
  logic        Valid, MemWrite, done, error;
  logic [31:0] DataAdr, WriteData;
  logic [31:0] ReadData = 32'h0;
  logic        Ready = 1'b0;
  logic        CacheHit = 1'b0;
  logic [15:0] hit_count, miss_count, mismatch_count;

  traffic_gen #(
    .NUM_OPS   (4),
    .BASE_ADDR (32'h0000_1000),
    .STRIDE    (16),
    .TIMEOUT   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .PID            (pid),
    .start          (start),
    .Valid          (Valid),
    .MemWrite       (MemWrite),
    .DataAdr        (DataAdr),
    .WriteData      (WriteData),
    .ReadData       (ReadData),
    .Ready          (Ready),
    .CacheHit       (CacheHit),
    .done           (done),
    .error          (error),
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .mismatch_count (mismatch_count)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Hand-computed per-PID region starts (NUM_OPS=4, STRIDE=16) and data tags.
  logic [31:0] base_tbl [4] = '{32'h0000_1000, 32'h0000_1040, 32'h0000_1080, 32'h0000_10C0};
  logic [31:0] tag_tbl  [4] = '{32'h00C0_0000, 32'h01C0_0000, 32'h02C0_0000, 32'h03C0_0000};

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_run(input int p);
    exp_t e;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 4; i++) begin
        e.we  = (ph == 0);
        e.adr = base_tbl[p] + 32'(i * 16);
        e.wd  = tag_tbl[p] | 32'(i);
        exp_q.push_back(e);
      end
    end
  endtask

  // L1 responder: Ready after lat cycles of Valid, stores writes, returns reads.
  int          lat = 3;
  logic        stall = 1'b0;
  logic        force_ready = 1'b0;
  logic        hit_wr = 1'b0;
  logic        hit_rd = 1'b0;
  logic [31:0] corrupt_addr = 32'hFFFF_FFFF;
  logic [31:0] mem [logic [31:0]];
  int          l1_cnt = 0;

  always @(negedge clk) begin
    if (reset || !Valid || stall) begin
      l1_cnt = 0;
      Ready  = force_ready;
    end else begin
      l1_cnt++;
      if (l1_cnt >= lat) begin
        Ready    = 1'b1;
        CacheHit = MemWrite ? hit_wr : hit_rd;
        if (MemWrite) begin
          mem[DataAdr] = WriteData;
        end else if (DataAdr == corrupt_addr) begin
          ReadData = 32'hDEAD_BEEF;
        end else begin
          ReadData = mem.exists(DataAdr) ? mem[DataAdr] : 32'h0;
        end
      end else begin
        Ready = 1'b0;
      end
    end
  end

  // Monitor: every handshake pops the next expected op; checks the one-cycle gap.
  int gap_chk = 0;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      gap_chk = 0;
    end else begin
      if (gap_chk == 1) begin
        chk("gap_valid", Valid, 1'b0);
        gap_chk = (exp_q.size() != 0) ? 2 : 0;
      end else if (gap_chk == 2) begin
        chk("next_valid", Valid, 1'b1);
        gap_chk = 0;
      end
      if (Valid && Ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_op", 32'(Valid), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("op_memwrite", MemWrite, e.we);
          chk("op_dataadr", DataAdr, e.adr);
          if (e.we) chk("op_writedata", WriteData, e.wd);
        end
        gap_chk = 1;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("done_seen", done, 1'b1);
    chk("sb_empty", exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, Valid, 1'b0);
    chk({tag, "_memwrite"}, MemWrite, 1'b0);
    chk({tag, "_dataadr"}, DataAdr, 32'h0);
    chk({tag, "_writedata"}, WriteData, 32'h0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_hit"}, hit_count, 16'h0);
    chk({tag, "_miss"}, miss_count, 16'h0);
    chk({tag, "_mismatch"}, mismatch_count, 16'h0);
  endtask

  task automatic check_counts(input string tag, input int h, input int m, input int mm, input logic err);
    chk({tag, "_hit"}, hit_count, 32'(h));
    chk({tag, "_miss"}, miss_count, 32'(m));
    chk({tag, "_mismatch"}, mismatch_count, 32'(mm));
    chk({tag, "_error"}, error, err);
  endtask

  int vcnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    pid   = 2'd0;
    repeat (3) @(negedge clk);
    #2;
    check_zero("reset");

    // Idle after reset; stray Ready must not count anything.
    reset       = 1'b0;
    force_ready = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    chk("idle_valid", Valid, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_hit", hit_count, 16'h0);
    chk("idle_miss", miss_count, 16'h0);
    force_ready = 1'b0;

    // PID 0, 3-cycle L1 latency, all misses.
    pid = 2'd0;
    lat = 3;
    push_run(0);
    pulse_start();
    wait_done(300);
    check_counts("run_p0", 0, 8, 0, 1'b0);

    // PID 1, read at idx 1 corrupted.
    pid          = 2'd1;
    lat          = 2;
    corrupt_addr = 32'h0000_1050;
    push_run(1);
    pulse_start();
    #2;
    chk("restart_done_clr", done, 1'b0);
    wait_done(300);
    check_counts("run_corrupt", 0, 8, 1, 1'b1);

    // PID 3, hits on reads only, a stray start mid-run.
    pid          = 2'd3;
    lat          = 1;
    corrupt_addr = 32'hFFFF_FFFF;
    hit_rd       = 1'b1;
    push_run(3);
    pulse_start();
    #2;
    chk("restart_err_clr", error, 1'b0);
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(300);
    check_counts("run_p3_hits", 4, 4, 0, 1'b0);

    // Reset pulsed while a request is outstanding, then a clean re-run.
    hit_rd = 1'b0;
    pid    = 2'd0;
    stall  = 1'b1;
    pulse_start();
    #2;
    chk("pre_reset_valid", Valid, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    stall = 1'b0;
    lat   = 3;
    push_run(0);
    pulse_start();
    wait_done(300);
    check_counts("rerun_p0", 0, 8, 0, 1'b0);

    // Ready held low forever.
    pid   = 2'd2;
    stall = 1'b1;
    pulse_start();
    #2;
    vcnt = Valid ? 1 : 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #2;
      if (Valid) vcnt++;
      else break;
    end
`ifdef TRAFFIC_GEN_WATCHDOG_EN
    chk("wd_valid_cycles", vcnt, 16);
    chk("wd_done", done, 1'b1);
    chk("wd_error", error, 1'b1);
    chk("wd_valid", Valid, 1'b0);
`else
    chk("nowd_valid_cycles", vcnt, 101);
    chk("nowd_done", done, 1'b0);
    chk("nowd_error", error, 1'b0);
    chk("nowd_valid", Valid, 1'b1);
`endif

    reset = 1'b1;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
